// File: rtl/pla_9sym_vecgen_if.sv
// Valid/ready stream that carries the matching 9-bit vectors out of the
// generator, plus the out_last flag that marks the final vector of a run.
interface pla_9sym_vecgen_if;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_vec;
  logic       out_last;

  modport master (output out_valid, out_vec, out_last, input  out_ready);
  modport slave  (input  out_valid, out_vec, out_last, output out_ready);
endinterface

// File: rtl/pla_9sym_vecgen.sv
// Enumerates, in ascending order, every 9-bit vector whose 9sym output
// (popcount in [LO_W, HI_W]) equals the requested target value.
module pla_9sym_vecgen #(
  parameter int unsigned LO_W = 3,
  parameter int unsigned HI_W = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      target,
  input  logic                      abort,
  pla_9sym_vecgen_if.master         stream,
  output logic                      busy,
  output logic                      done,
  output logic [9:0]                count
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_e;

  function automatic int unsigned pop9(input logic [8:0] v);
    int unsigned n = 0;
    for (int i = 0; i < 9; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic in_band(input logic [8:0] v);
    int unsigned p = pop9(v);
    return (p >= LO_W) && (p <= HI_W);
  endfunction

  // Highest matching vector for each target; the EMIT of this vector ends the run.
  function automatic logic [8:0] last_match(input logic tgt);
    logic [8:0] r = '0;
    for (int v = 0; v < 512; v++)
      if (in_band(9'(v)) == tgt) r = 9'(v);
    return r;
  endfunction

  localparam logic [8:0] LAST_T1 = last_match(1'b1);
  localparam logic [8:0] LAST_T0 = last_match(1'b0);

  state_e     state_q, state_d;
  logic [8:0] cand_q;
  logic       target_q;
  logic [8:0] vec_q;
  logic       last_q;
  logic [9:0] count_q;

  logic match;
  logic is_last;
  logic handshake;

  assign match     = (in_band(cand_q) == target_q);
  assign is_last   = (cand_q == (target_q ? LAST_T1 : LAST_T0));
  assign handshake = (state_q == EMIT) && stream.out_ready;

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned -- that is what keeps latches from being inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = SCAN;
      SCAN: begin
        if (abort)                  state_d = IDLE;
        else if (match)             state_d = EMIT;
        else if (cand_q == 9'h1FF)  state_d = DONE;
      end
      EMIT: begin
        if (abort)          state_d = IDLE;
        else if (handshake) state_d = last_q ? DONE : SCAN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and simulation matches the flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      target_q <= 1'b0;
      vec_q    <= '0;
      last_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            target_q <= target;
            cand_q   <= '0;
            count_q  <= '0;
          end
        end
        SCAN: begin
          if (!abort) begin
            if (match) begin
              vec_q  <= cand_q;
              last_q <= is_last;
            end else if (cand_q != 9'h1FF) begin
              cand_q <= cand_q + 9'd1;
            end
          end
        end
        EMIT: begin
          // The last vector is the highest match, so cand never wraps here.
          if (!abort && handshake) begin
            count_q <= count_q + 10'd1;
            if (!last_q) cand_q <= cand_q + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign stream.out_valid = (state_q == EMIT);
  assign stream.out_vec   = vec_q;
  assign stream.out_last  = last_q;
  assign busy             = (state_q == SCAN) || (state_q == EMIT);
  assign done             = (state_q == DONE);
  assign count            = count_q;

endmodule

// File: tb/tb_pla_9sym_vecgen.sv
// Directed bench for pla_9sym_vecgen: table of full runs plus hand-written
// abort, restart, parameter and mid-run reset sequences.
module tb_pla_9sym_vecgen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, target = 1'b0, abort = 1'b0;
  logic       busy, done;
  logic [9:0] count;

  logic       p_start = 1'b0, p_target = 1'b0, p_abort = 1'b0;
  logic       p_busy, p_done;
  logic [9:0] p_count;

  pla_9sym_vecgen_if bus ();
  pla_9sym_vecgen_if bus_p ();

  pla_9sym_vecgen u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target), .abort(abort),
    .stream(bus.master), .busy(busy), .done(done), .count(count)
  );

  pla_9sym_vecgen #(.LO_W(9), .HI_W(9)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .start(p_start), .target(p_target), .abort(p_abort),
    .stream(bus_p.master), .busy(p_busy), .done(p_done), .count(p_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       tgt;
    bit         rnd;     // random out_ready
    bit         poke;    // flipped-target start while busy
    logic [8:0] first;
    logic [8:0] second;
    logic [8:0] last;
    int         n;
    int         busy_cyc; // -1: not checked
  } run_t;

  run_t runs [4];

  function automatic bit in_3_6(input logic [8:0] v);
    int p = $countones(v);
    return (p >= 3) && (p <= 6);
  endfunction

  task automatic do_run(input run_t r);
    logic [8:0] exp_q [$];
    int         idx = 0, busy_cyc = 0, cyc = 0, last_hs = -10, done_cyc = -1;
    bit         stalled = 0, stall_ok = 1, order_ok = 1, last_ok = 1, band_ok = 1;
    logic [8:0] held = '0, got_first = '0, got_second = '0, got_last = '0;
    int         p;

    for (int v = 0; v < 512; v++)
      if (in_3_6(9'(v)) == r.tgt) exp_q.push_back(9'(v));

    start  = 1'b1;
    target = r.tgt;
    while (cyc < 4000 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      start  = 1'b0;
      target = r.tgt;
      if (r.poke && (cyc == 40 || cyc == 300)) begin
        start  = 1'b1;
        target = ~r.tgt;
      end
      if (stalled && !(bus.out_valid && bus.out_vec == held)) stall_ok = 0;
      busy_cyc += int'(busy);
      if (done) done_cyc = cyc;
      bus.out_ready = r.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_vec;
      if (bus.out_valid && bus.out_ready) begin
        if (idx == 0) got_first  = bus.out_vec;
        if (idx == 1) got_second = bus.out_vec;
        got_last = bus.out_vec;
        if (idx >= exp_q.size() || bus.out_vec != exp_q[idx]) order_ok = 0;
        if (bus.out_last != (idx == r.n - 1)) last_ok = 0;
        p = $countones(bus.out_vec);
        if (r.tgt ? !(p >= 3 && p <= 6) : !(p <= 2 || p >= 7)) band_ok = 0;
        idx++;
        last_hs = cyc;
      end
    end
    start = 1'b0;
    bus.out_ready = 1'b0;

    check($sformatf("run_t%0d_timeout", r.tgt), (done_cyc < 0), 0);
    check($sformatf("run_t%0d_nvec", r.tgt), idx, r.n);
    check($sformatf("run_t%0d_count", r.tgt), count, r.n);
    check($sformatf("run_t%0d_first", r.tgt), got_first, r.first);
    check($sformatf("run_t%0d_second", r.tgt), got_second, r.second);
    check($sformatf("run_t%0d_last", r.tgt), got_last, r.last);
    check($sformatf("run_t%0d_sequence", r.tgt), order_ok, 1);
    check($sformatf("run_t%0d_out_last", r.tgt), last_ok, 1);
    check($sformatf("run_t%0d_popcount", r.tgt), band_ok, 1);
    check($sformatf("run_t%0d_stall_hold", r.tgt), stall_ok, 1);
    check($sformatf("run_t%0d_done_delay", r.tgt), done_cyc - last_hs, 1);
    if (r.busy_cyc >= 0) check($sformatf("run_t%0d_busy_cycles", r.tgt), busy_cyc, r.busy_cyc);
    @(negedge clk);
    check($sformatf("run_t%0d_done_pulse", r.tgt), done, 0);
    check($sformatf("run_t%0d_idle_busy", r.tgt), busy, 0);
    check($sformatf("run_t%0d_count_hold", r.tgt), count, r.n);
  endtask

  initial begin
    int  hs;
    bit  got, dseen, pdone;
    int  phs;
    logic [8:0] pvec;
    logic       plast;

    bus.out_ready   = 1'b0;
    bus_p.out_ready = 1'b0;

    runs[0] = '{tgt: 1'b1, rnd: 1'b0, poke: 1'b0, first: 9'h007, second: 9'h00B, last: 9'h1F8, n: 420, busy_cyc: 925};
    runs[1] = '{tgt: 1'b0, rnd: 1'b0, poke: 1'b0, first: 9'h000, second: 9'h001, last: 9'h1FF, n: 92,  busy_cyc: 604};
    runs[2] = '{tgt: 1'b1, rnd: 1'b1, poke: 1'b0, first: 9'h007, second: 9'h00B, last: 9'h1F8, n: 420, busy_cyc: -1};
    runs[3] = '{tgt: 1'b0, rnd: 1'b0, poke: 1'b1, first: 9'h000, second: 9'h001, last: 9'h1FF, n: 92,  busy_cyc: 604};

    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.out_valid, bus.out_vec, bus.out_last, busy, done, count}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {bus.out_valid, busy, done}, 0);

    for (int i = 0; i < 4; i++) do_run(runs[i]);

    // Abort while the third vector is held with out_ready low.
    hs = 0; got = 0;
    start = 1'b1; target = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.out_valid && hs < 2) begin
        bus.out_ready = 1'b1;
        hs++;
      end else begin
        bus.out_ready = 1'b0;
        if (bus.out_valid) got = 1;
      end
    end
    check("abort_reach_third", got, 1);
    check("abort_third_vec", bus.out_vec, 9'h00D);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid_drop", bus.out_valid, 0);
    check("abort_busy_drop", busy, 0);
    check("abort_count_hold", count, 2);
    dseen = 0;
    for (int c = 0; c < 5; c++) begin
      if (done) dseen = 1;
      @(negedge clk);
    end
    check("abort_no_done", dseen, 0);

    // Restart after abort begins again from the first match.
    got = 0;
    start = 1'b1; target = 1'b1;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.out_valid) got = 1;
    end
    check("restart_valid", got, 1);
    check("restart_first_vec", bus.out_vec, 9'h007);
    check("restart_count_clear", count, 0);

    // Asynchronous reset while EMIT holds a vector.
    #2 rst_n = 1'b0;
    #1 check("midrun_reset_outputs", {bus.out_valid, bus.out_vec, bus.out_last, busy, done, count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrun_reset_stays_idle", {bus.out_valid, busy}, 0);

    // Single-vector run on the LO_W=HI_W=9 instance.
    phs = 0; pdone = 0; pvec = '0; plast = 1'b0;
    bus_p.out_ready = 1'b1;
    p_start = 1'b1; p_target = 1'b1;
    for (int c = 0; c < 1000 && !pdone; c++) begin
      @(negedge clk);
      p_start = 1'b0;
      if (p_done) pdone = 1;
      if (bus_p.out_valid && bus_p.out_ready) begin
        phs++;
        pvec  = bus_p.out_vec;
        plast = bus_p.out_last;
      end
    end
    check("param_done", pdone, 1);
    check("param_nvec", phs, 1);
    check("param_vec", pvec, 9'h1FF);
    check("param_last", plast, 1);
    check("param_count", p_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
